// File: rtl/bmem_burst_responder.sv
// Memory-side end of the 64-bit bmem link: DEPTH x 256-bit line store, four-beat
// line writes, queued line reads returned as four beats after a fixed latency.

module bmem_rq_slot #(
  parameter int LATENCY = 4,
  parameter int CW      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [26:0]  load_addr,
  input  logic [255:0] load_line,
  output logic [26:0]  addr,
  output logic [255:0] line,
  output logic         due
);
  logic [CW-1:0] cd;

  always_ff @(posedge clk) begin
    if (rst) begin
      cd   <= '0;
      addr <= '0;
      line <= '0;
    end else if (load) begin
      cd   <= CW'(LATENCY - 1);
      addr <= load_addr;
      line <= load_line;
    end else if (cd != '0) begin
      cd <= cd - 1'b1;
    end
  end

  assign due = (cd == '0);
endmodule

module bmem_burst_responder #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int NW = $clog2(QDEPTH + 1);
  localparam int CW = $clog2(LATENCY + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [255:0] mem [DEPTH];
  logic [1:0]   wcnt;
  logic [IW-1:0] widx;
  // Beat 3 goes straight from bmem_wdata into the array, so only 3 beats are staged.
  logic [191:0] stage;

  logic [PW-1:0] wptr, rptr;
  logic [NW-1:0] qcount;
  logic [QDEPTH-1:0][26:0]  slot_addr;
  logic [QDEPTH-1:0][255:0] slot_line;
  logic [QDEPTH-1:0]        slot_due;

  logic [0:0] state;
  logic [1:0] bcnt;
  logic       wr_acc, rd_acc, deq, start;
  logic [IW-1:0]  rd_idx;
  logic [255:0]   head_line;
  logic           unused_bits;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_bits = ^bmem_addr[4:0];
  assign rd_idx      = bmem_addr[5 +: IW];
  assign bmem_ready  = !rst && ((wcnt != 2'd0) || (qcount != NW'(QDEPTH)));
  assign wr_acc      = bmem_ready && bmem_write;
  assign rd_acc      = bmem_ready && bmem_read && !bmem_write && (wcnt == 2'd0);
  assign head_line   = slot_line[rptr];
  assign deq         = (state == S_BURST) && (bcnt == 2'd3);
  assign start       = (state == S_IDLE) && (qcount != '0) && slot_due[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wcnt  <= '0;
      widx  <= '0;
      stage <= '0;
    end else if (wr_acc) begin
      unique case (wcnt)
        2'd0: begin
          stage[63:0] <= bmem_wdata;
          widx        <= rd_idx;
        end
        2'd1: stage[127:64]  <= bmem_wdata;
        2'd2: stage[191:128] <= bmem_wdata;
        default: mem[widx] <= {bmem_wdata, stage};
      endcase
      wcnt <= wcnt + 2'd1;
    end
  end

  // Snapshot is taken from the array at accept time; a read can never be
  // accepted on the edge a write commits, so no bypass is needed.
  for (genvar g = 0; g < QDEPTH; g++) begin : g_slot
    bmem_rq_slot #(.LATENCY(LATENCY), .CW(CW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (rd_acc && (wptr == PW'(g))),
      .load_addr (bmem_addr[31:5]),
      .load_line (mem[rd_idx]),
      .addr      (slot_addr[g]),
      .line      (slot_line[g]),
      .due       (slot_due[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      qcount <= '0;
    end else begin
      if (rd_acc) wptr <= nxt(wptr);
      if (deq)    rptr <= nxt(rptr);
      qcount <= qcount + NW'(rd_acc) - NW'(deq);
    end
  end

  // Beat 3 dequeues and drops back to IDLE with rvalid still high, so a due
  // head entry starts its beat 0 on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bcnt        <= '0;
      bmem_rvalid <= 1'b0;
      bmem_rdata  <= '0;
      bmem_raddr  <= '0;
    end else if (start) begin
      state       <= S_BURST;
      bcnt        <= 2'd1;
      bmem_rvalid <= 1'b1;
      bmem_rdata  <= head_line[63:0];
      bmem_raddr  <= {slot_addr[rptr], 5'b0};
    end else if (state == S_BURST) begin
      bmem_rdata <= head_line[{bcnt, 6'b0} +: 64];
      bcnt       <= bcnt + 2'd1;
      if (bcnt == 2'd3) state <= S_IDLE;
    end else begin
      bmem_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bmem_burst_responder.sv
// Bench for bmem_burst_responder: timestamp-based reference model plus a vector
// table and directed multi-cycle sequences.

module tb_bmem_burst_responder;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 4;
  localparam int QDEPTH  = 4;
  localparam int IW      = $clog2(DEPTH);
  localparam int MAXC    = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0, bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready, bmem_rvalid;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;

  always #5 clk = ~clk;

  bmem_burst_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int n_tests = 0, n_fail = 0;

  // Reference model: each accepted read gets a start cycle
  // max(accept + LATENCY, previous start + 4); beats land at start..start+3.
  logic [255:0] mmem [DEPTH];
  int           wc, widx, last_s, E;
  logic [255:0] wstage;
  int           starts[$];
  bit           exp_v [MAXC];
  logic [63:0]  exp_d [MAXC];
  logic [31:0]  exp_a [MAXC];
  logic [63:0]  last_d;
  logic [31:0]  last_a;
  int           vcount, vfirst, vlast;

  typedef struct {
    bit rd, wr; logic [31:0] addr; logic [63:0] wd;
    bit er, ev; logic [63:0] ed; logic [31:0] ea;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, E, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    wc = 0; widx = 0; wstage = '0; last_s = -100;
    starts.delete();
    for (int i = E + 1; i < MAXC; i++) exp_v[i] = 1'b0;
    last_d = '0; last_a = '0;
  endtask

  task automatic cycle(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [63:0] wd, output bit rdy, output bit vld,
                       output logic [63:0] d, output logic [31:0] ad);
    bit rdy_m;
    int s, idx;
    if (E >= MAXC - 12) begin
      $display("FAIL cycle_budget exhausted at %0d", E);
      $fatal(1);
    end
    rst = r; bmem_read = rd; bmem_write = wr; bmem_addr = a; bmem_wdata = wd;
    #1;
    while (starts.size() > 0 && starts[0] + 3 <= E) void'(starts.pop_front());
    rdy_m = !r && (wc != 0 || starts.size() < QDEPTH);
    if (exp_v[E]) begin last_d = exp_d[E]; last_a = exp_a[E]; end
    chk("ready",  64'(bmem_ready),  64'(rdy_m));
    chk("rvalid", 64'(bmem_rvalid), 64'(exp_v[E]));
    chk("rdata",  bmem_rdata, last_d);
    chk("raddr",  64'(bmem_raddr), 64'(last_a));
    rdy = bmem_ready; vld = bmem_rvalid; d = bmem_rdata; ad = bmem_raddr;
    if (bmem_rvalid) begin
      vcount++;
      if (vfirst < 0) vfirst = E;
      vlast = E;
    end
    if (r) model_reset();
    else if (rdy_m) begin
      if (wr) begin
        if (wc == 0) widx = int'(a[5 +: IW]);
        wstage[64*wc +: 64] = wd;
        if (wc == 3) mmem[widx] = wstage;
        wc = (wc + 1) % 4;
      end else if (rd && wc == 0) begin
        s = (E + 1 + LATENCY > last_s + 4) ? E + 1 + LATENCY : last_s + 4;
        idx = int'(a[5 +: IW]);
        for (int k = 0; k < 4; k++) begin
          exp_v[s+k] = 1'b1;
          exp_d[s+k] = mmem[idx][64*k +: 64];
          exp_a[s+k] = {a[31:5], 5'b0};
        end
        starts.push_back(s);
        last_s = s;
      end
    end
    @(posedge clk);
    E++;
    @(negedge clk);
  endtask

  bit          g_rdy, g_vld;
  logic [63:0] g_d;
  logic [31:0] g_a;

  task automatic go(input bit r, input bit rd, input bit wr, input logic [31:0] a, input logic [63:0] wd);
    cycle(r, rd, wr, a, wd, g_rdy, g_vld, g_d, g_a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(0, 0, 0, '0, '0);
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [31:0] tag);
    for (int k = 0; k < 4; k++) go(0, 0, 1, a, {tag, 32'(k)});
  endtask

  task automatic push(input bit rd, input bit wr, input logic [31:0] a, input logic [63:0] wd,
                      input bit ev, input logic [63:0] ed, input logic [31:0] ea);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.er = 1'b1; v.ev = ev; v.ed = ed; v.ea = ea;
    tbl.push_back(v);
  endtask

  task automatic push_read(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3, input logic [31:0] ea);
    push(1, 0, a, '0, 0, '0, '0);
    for (int i = 0; i < LATENCY; i++) push(0, 0, '0, '0, 0, '0, '0);
    push(0, 0, '0, '0, 1, d0, ea);
    push(0, 0, '0, '0, 1, d1, ea);
    push(0, 0, '0, '0, 1, d2, ea);
    push(0, 0, '0, '0, 1, d3, ea);
  endtask

  initial begin
    logic [63:0] p1, p2, p3, p4;
    int waited;
    bit rd, wr;
    logic [31:0] a;
    p1 = 64'h1111111111111111; p2 = 64'h2222222222222222;
    p3 = 64'h3333333333333333; p4 = 64'h4444444444444444;

    repeat (2) @(posedge clk);
    @(negedge clk);
    E = 0;
    model_reset();
    vfirst = -1; vcount = 0; vlast = -1;

    // Reset state: ready low while rst is high, outputs cleared.
    go(1, 0, 0, '0, '0);
    chk("reset_ready", 64'(g_rdy), 64'd0);
    go(1, 1, 0, 32'h40, '0);
    chk("reset_rvalid", 64'(g_vld), 64'd0);

    // Vector table: read of a cleared line, write with a gap, aliased and unaligned reads.
    push_read(32'h40, '0, '0, '0, '0, 32'h40);
    push(0, 1, 32'h20, p1, 0, '0, '0);
    push(0, 1, 32'h00, p2, 0, '0, '0);
    push(0, 0, '0, '0, 0, '0, '0);
    push(0, 1, 32'h00, p3, 0, '0, '0);
    push(0, 1, 32'h00, p4, 0, '0, '0);
    push_read(32'h20, p1, p2, p3, p4, 32'h20);
    push_read(32'h20 + 32 * DEPTH, p1, p2, p3, p4, 32'h20 + 32 * DEPTH);
    push_read(32'h47, '0, '0, '0, '0, 32'h40);
    push(0, 0, '0, '0, 0, '0, '0);
    foreach (tbl[i]) begin
      go(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
      chk($sformatf("tbl%0d_ready", i), 64'(g_rdy), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_rvalid", i), 64'(g_vld), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_rdata", i), g_d, tbl[i].ed);
        chk($sformatf("tbl%0d_raddr", i), 64'(g_a), 64'(tbl[i].ea));
      end
    end

    // Five back-to-back reads into a 4-deep queue.
    for (int i = 1; i <= 5; i++) wr_line(32'(i * 32), 32'hA000 + 32'(i));
    idle(2);
    vfirst = -1; vcount = 0; vlast = -1;
    for (int i = 1; i <= 4; i++) begin
      go(0, 1, 0, 32'(i * 32), '0);
      chk("q_accept", 64'(g_rdy), 64'd1);
    end
    waited = 0;
    for (int t = 0; t < 20; t++) begin
      go(0, 1, 0, 32'(5 * 32), '0);
      if (g_rdy) break;
      waited++;
    end
    chk("q_full_wait", 64'(waited), 64'd4);
    idle(30);
    chk("q_beats", 64'(vcount), 64'd20);
    chk("q_contiguous", 64'(vlast - vfirst + 1), 64'd20);

    // Read right after write beat 3; then read+write together (write wins).
    vfirst = -1; vcount = 0; vlast = -1;
    wr_line(32'hC0, 32'hBEEF);
    go(0, 1, 0, 32'hC0, '0);
    go(0, 1, 1, 32'hE0, 64'hCAFE0000);
    go(0, 0, 1, 32'h0, 64'hCAFE0001);
    go(0, 0, 1, 32'h0, 64'hCAFE0002);
    go(0, 0, 1, 32'h0, 64'hCAFE0003);
    idle(20);
    chk("rw_beats", 64'(vcount), 64'd4);
    go(0, 1, 0, 32'hE0, '0);
    idle(10);

    // Reset during beat 1 of a read burst.
    go(0, 1, 0, 32'hC0, '0);
    waited = 0;
    for (int t = 0; t < 20 && !g_vld; t++) begin
      go(0, 0, 0, '0, '0);
      waited++;
    end
    chk("rst_wait_beat0", 64'(g_vld), 64'd1);
    go(1, 0, 0, '0, '0);
    chk("rst_during_beat1", 64'(g_vld), 64'd1);
    vfirst = -1; vcount = 0; vlast = -1;
    go(0, 0, 0, '0, '0);
    chk("rst_rvalid_low", 64'(g_vld), 64'd0);
    idle(10);
    chk("rst_no_beats", 64'(vcount), 64'd0);

    // Reset during write beat 2 discards the partial line.
    go(0, 0, 1, 32'h60, 64'h5555);
    go(0, 0, 1, 32'h60, 64'h6666);
    go(1, 0, 1, 32'h60, 64'h7777);
    go(0, 1, 0, 32'h60, '0);
    for (int t = 0; t < 20 && !g_vld; t++) go(0, 0, 0, '0, '0);
    chk("rst_wr_line0", g_d, 64'd0);
    idle(8);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      wr = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 9) < 4);
      a  = (32'($urandom_range(0, 2 * DEPTH - 1)) << 5) | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      go(0, rd, wr, a, {$urandom, $urandom});
    end
    idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bmem_burst_responder.md
Name: bmem_burst_responder

Overview:
- Synthesizable burst-memory responder: the memory-side end of the 64-bit bmem link that the cache-side deserializer talks to.
- Stores DEPTH cache lines of 256 bits.
- Accepts line reads and returns each one as four 64-bit beats after a fixed latency.
- Accepts four-beat line writes.
- Used as the bmem model in cache and deserializer benches, and as on-chip backing store in small configurations.

Parameters:
- DEPTH, 16, number of 256-bit lines stored; must be a power of two, at least 2.
- LATENCY, 4, cycles from read acceptance to first rvalid beat; minimum 1.
- QDEPTH, 4, maximum outstanding accepted reads; power of two, at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- bmem_addr  in  32  line address; bits [4:0] ignored; index = addr[5+log2(DEPTH)-1:5]; upper bits alias
- bmem_read  in  1  read request, sampled with bmem_ready
- bmem_write  in  1  write beat valid, sampled with bmem_ready
- bmem_wdata  in  64  write beat data
- bmem_ready  out  1  request/beat accepted this cycle when high
- bmem_raddr  out  32  address of the line being returned (aligned, bits [4:0]=0)
- bmem_rdata  out  64  read beat data
- bmem_rvalid  out  1  read beat valid

Behaviour:
- Reset:
  - While rst is high: bmem_ready=0, bmem_rvalid=0, bmem_rdata=0, bmem_raddr=0.
  - The read queue, write beat counter and output beat counter are cleared.
  - All array lines are cleared to 0.
  - Reset mid-burst abandons the burst: no further beats are produced, and a partial write is discarded.
- bmem_ready:
  - Combinational, from registered state.
  - High when not in reset, and either a write burst is in progress (write beat count ≠ 0) or the read queue holds fewer than QDEPTH entries.
  - Inputs are registered as accepted only on cycles where bmem_ready=1.
- Write burst:
  - Four accepted beats with bmem_write=1. Beat k fills bits [64k+63:64k] of a 256-bit staging register.
  - The address is captured on beat 0; bmem_addr on later beats is ignored.
  - On the cycle beat 3 is accepted, the staged line commits to the array at the next clock edge.
  - Gaps between beats (bmem_write=0) are allowed. The counter holds its value and wraps 3→0.
- Read accept:
  - bmem_read=1 with bmem_ready=1 and write beat count=0 enqueues an entry: aligned address, a snapshot of the addressed line, and a countdown initialised to LATENCY-1.
  - The snapshot comes from the array after any write committing on the same edge. A read accepted the cycle after a write's beat 3 sees the new data.
  - Read and write asserted together: the write wins and the read is not enqueued.
  - A read asserted during a write burst is ignored.
- Countdown: every entry's countdown decrements each cycle and saturates at 0.
- Output sequencer, states IDLE and BURST:
  - IDLE→BURST when the queue is non-empty and the head countdown is 0. On that cycle's edge, beat 0 is registered.
  - In BURST, beats 1..3 are output on the following consecutive cycles. bmem_rvalid stays high for exactly 4 cycles.
  - Beat k carries bits [64k+63:64k]. bmem_raddr holds the entry address for all 4 beats.
  - After beat 3: dequeue. If the next head's countdown is already 0, its beat 0 follows with no bubble. Otherwise go to IDLE.
  - Timing: a read accepted at edge t, with an idle sequencer, gives beat 0 valid in the cycle starting LATENCY cycles after edge t.
- Queue:
  - Enqueue and dequeue in the same cycle are allowed.
  - Full means count=QDEPTH, which drops ready (unless a write burst is in progress).
  - Pointers wrap modulo QDEPTH.
- Idle outputs: when bmem_rvalid=0, bmem_rdata and bmem_raddr hold their last values.

Test Plan:
- Reset, then read addr 0x40 → ready=1; 4 beats of 0 with raddr=0x40, first beat exactly LATENCY cycles after accept; rvalid high 4 consecutive cycles.
- Write addr 0x20, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with one idle gap after beat 1; then read 0x20 → beats return in order 0x11.., 0x22.., 0x33.., 0x44..; read of 0x20+32*DEPTH aliases and returns the same data.
- Five reads back-to-back with QDEPTH=4 → ready drops after the 4th accept; 5th accepted after the first dequeue; bursts contiguous with no bubbles between them; addresses returned in order.
- Read accepted the cycle after write beat 3 to the same line → returns the new data; read and write asserted in the same cycle → write committed, no rvalid burst produced for that read.
- rst asserted during beat 1 of a read burst and during write beat 2 → rvalid=0 the next cycle; no further beats; later read of the written line returns 0.
- Unaligned read addr 0x47 → raddr=0x40 on all beats.
